// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: serve/step/bounce/score sequencer for the pong ball position unit
module pong_ball_ctrl #(
  parameter int WIDTH = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int PADDLE_H = 3,
  parameter int TICK_DIV = 16,
  parameter int WIN_SCORE = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIT_OF_WIDTH-1:0] x_pos,
  input  logic [BIT_OF_WIDTH-1:0] y_pos,
  input  logic [BIT_OF_WIDTH-1:0] paddle_l,
  input  logic [BIT_OF_WIDTH-1:0] paddle_r,
  output logic                    ball_en,
  output logic                    step,
  output logic [3:0]              vector,
  output logic [3:0]              score_l,
  output logic [3:0]              score_r,
  output logic                    point,
  output logic                    game_over,
  output logic [2:0]              ctrl_state
);
  typedef enum logic [2:0] {SERVE = 3'd0, WAIT = 3'd1, EVAL = 3'd2, STEP = 3'd3, POINT = 3'd4, OVER = 3'd5} state_t;
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TICK_DIV - 1);
  localparam logic [BIT_OF_WIDTH-1:0] X_ONE = BIT_OF_WIDTH'(1);
  localparam logic [BIT_OF_WIDTH-1:0] X_LAST = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [BIT_OF_WIDTH-1:0] X_NEXT = BIT_OF_WIDTH'(WIDTH - 2);
  localparam logic [BIT_OF_WIDTH:0] N_LAST = (BIT_OF_WIDTH+1)'(WIDTH - 1);
  localparam logic [BIT_OF_WIDTH:0] PH_M1 = (BIT_OF_WIDTH+1)'(PADDLE_H - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] vec_n, sl_n, sr_n;
  logic dir, dir_n;
  logic [1:0] vx, vy, vy_b;
  logic [BIT_OF_WIDTH:0] ny, pl_end, pr_end;
  logic hit_l, hit_r;
  assign vx = vector[3:2];
  assign vy = vector[1:0];
  assign ctrl_state = state;
  // paddle ends are computed one bit wider so a paddle near the bottom cannot wrap to the top
  always_comb begin
    vy_b = (y_pos == '0 && vy == 2'b11) ? 2'b01 : (y_pos == X_LAST && vy == 2'b01) ? 2'b11 : vy;
    ny = {1'b0, y_pos} + {{(BIT_OF_WIDTH-1){vy_b[1]}}, vy_b};
    pl_end = {1'b0, paddle_l} + PH_M1;
    pr_end = {1'b0, paddle_r} + PH_M1;
    hit_l = x_pos == X_ONE && vx == 2'b11 && ny >= {1'b0, paddle_l} && ny <= pl_end && ny <= N_LAST;
    hit_r = x_pos == X_NEXT && vx == 2'b01 && ny >= {1'b0, paddle_r} && ny <= pr_end && ny <= N_LAST;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    vec_n = vector;
    sl_n = score_l;
    sr_n = score_r;
    dir_n = dir;
    case (state)
      SERVE: if (start) begin
        state_n = WAIT;
        cnt_n = CNT_LOAD;
        vec_n = {dir, 1'b1, 2'b01};
      end
      WAIT: begin
        state_n = cnt == '0 ? EVAL : WAIT;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end
      EVAL: if (x_pos == '0 || x_pos == X_LAST) begin
        state_n = POINT;
        vec_n = '0;
        sr_n = (x_pos == '0 && score_r != WIN) ? score_r + 4'd1 : score_r;
        sl_n = (x_pos == X_LAST && score_l != WIN) ? score_l + 4'd1 : score_l;
        dir_n = x_pos == '0;
      end else begin
        state_n = STEP;
        vec_n = {hit_l ? 2'b01 : hit_r ? 2'b11 : vx, vy_b};
      end
      STEP: begin
        state_n = WAIT;
        cnt_n = CNT_LOAD;
      end
      POINT: state_n = (score_l == WIN || score_r == WIN) ? OVER : SERVE;
      OVER: if (start) begin
        state_n = SERVE;
        sl_n = '0;
        sr_n = '0;
        dir_n = 1'b0;
      end
      default: state_n = SERVE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SERVE;
      cnt <= '0;
      vector <= '0;
      score_l <= '0;
      score_r <= '0;
      dir <= 1'b0;
      ball_en <= 1'b0;
      step <= 1'b0;
      point <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      vector <= vec_n;
      score_l <= sl_n;
      score_r <= sr_n;
      dir <= dir_n;
      ball_en <= state_n == WAIT || state_n == EVAL || state_n == STEP;
      step <= state_n == STEP;
      point <= state_n == POINT;
      game_over <= state_n == OVER;
    end
  end
endmodule
